data_mem_be: RTL and testbench

Parametrised byte-addressed data memory for the MIPS32 core, the successor to the single-cycle word-only data memory. It supports byte, halfword and word loads and stores with sign/zero extension, a registered one-cycle read, and alignment and range checking. After reset it zeroes its own contents before accepting accesses. It sits in the MEM stage between the ALU address output and the write-back mux.

---
 rtl/mips_mem_pkg.sv | 35 +++
 rtl/data_mem_align.sv | 50 +++++
 rtl/data_mem_be.sv | 156 +++++++++++++++
 tb/tb_data_mem_be.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MIPS32 byte-enabled data memory.
// This package holds the access-size codes, the controller states and the load-extension helper.
package mips_mem_pkg;

  // Access size codes carried on i_size.
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  // Controller states.
  // CLEAR zeroes the array one word per cycle.
  // IDLE accepts requests.
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } mem_state_e;

  // Widen a right-justified byte or half to 32 bits.
  // Word results pass through unchanged, whatever the unsigned flag says.
  function automatic logic [31:0] extend_load(input logic [31:0] value,
                                              input logic [1:0]  size,
                                              input logic        is_unsigned);
    logic [31:0] result;
    case (size)
      SZ_BYTE: result = is_unsigned ? {24'h0, value[7:0]}
                                    : {{24{value[7]}}, value[7:0]};
      SZ_HALF: result = is_unsigned ? {16'h0, value[15:0]}
                                    : {{16{value[15]}}, value[15:0]};
      default: result = value;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/data_mem_align.sv
// Lane steering for the data memory.
// Store side: turns size and lane into byte enables and replicates store data across the lanes.
// Load side: picks the addressed lanes out of the raw word and extends them.
module data_mem_align
  import mips_mem_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_lane,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  input  logic        i_unsigned,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata,
  output logic        o_misaligned
);

  logic [31:0] lane_data;

  // Decode size/lane into enables, steered store data, raw load lanes and the alignment fault.
  always_comb begin
    o_be         = 4'b0000;
    o_wdata      = i_wdata;
    lane_data    = 32'h0;
    o_misaligned = 1'b0;
    case (i_size)
      SZ_BYTE: begin
        o_be      = 4'b0001 << i_lane;
        o_wdata   = {4{i_wdata[7:0]}};
        lane_data = {24'h0, i_rdata[{i_lane, 3'b000} +: 8]};
      end
      SZ_HALF: begin
        o_misaligned = i_lane[0];
        o_be         = i_lane[1] ? 4'b1100 : 4'b0011;
        o_wdata      = {2{i_wdata[15:0]}};
        lane_data    = {16'h0, (i_lane[1] ? i_rdata[31:16] : i_rdata[15:0])};
      end
      SZ_WORD: begin
        o_misaligned = |i_lane;
        o_be         = 4'b1111;
        lane_data    = i_rdata;
      end
      default: begin
        o_misaligned = 1'b1;
      end
    endcase
    o_rdata = extend_load(lane_data, i_size, i_unsigned);
  end

endmodule

// File: rtl/data_mem_be.sv
// Byte-addressed MEM-stage data memory.
// Supports byte, halfword and word access with a registered one-cycle load.
// Checks every access for alignment and address range, and zeroes its own array after reset.
module data_mem_be
  import mips_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS    = 256,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_MemWrite,
  input  logic        i_MemRead,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic [31:0] i_address,
  input  logic [31:0] i_data,
  output logic [31:0] o_data,
  output logic        o_valid,
  output logic        o_ready,
  output logic        o_misaligned,
  output logic        o_out_of_range
);

  localparam int             AW          = $clog2(DEPTH_WORDS);
  localparam logic [AW-1:0]  LAST_IDX    = AW'(DEPTH_WORDS - 1);
  localparam mem_state_e     RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;

  mem_state_e     state_q, state_d;
  logic [AW-1:0]  clr_cnt_q, clr_cnt_d;
  logic [31:0]    data_q, data_d;
  logic           valid_q, valid_d;
  logic           misaligned_q, misaligned_d;
  logic           out_of_range_q, out_of_range_d;

  logic [31:0]    mem_q [DEPTH_WORDS];

  logic [AW-1:0]  word_idx;
  logic [31:0]    rd_word;
  logic [3:0]     acc_be;
  logic [31:0]    acc_wdata;
  logic [31:0]    acc_rdata;
  logic           acc_misaligned;
  logic           acc_out_of_range;
  logic           accept;
  logic           fault;

  logic           wr_en;
  logic [AW-1:0]  wr_idx;
  logic [3:0]     wr_be;
  logic [31:0]    wr_data;

  assign word_idx         = i_address[AW+1:2];
  assign rd_word          = mem_q[word_idx];
  assign acc_out_of_range = (i_address >> (AW + 2)) != 32'h0;
  assign o_ready          = (state_q == ST_IDLE);
  assign accept           = o_ready && (i_MemRead || i_MemWrite);
  assign fault            = acc_misaligned || acc_out_of_range;

  data_mem_align u_align (
    .i_size       (i_size),
    .i_lane       (i_address[1:0]),
    .i_wdata      (i_data),
    .i_rdata      (rd_word),
    .i_unsigned   (i_unsigned),
    .o_be         (acc_be),
    .o_wdata      (acc_wdata),
    .o_rdata      (acc_rdata),
    .o_misaligned (acc_misaligned)
  );

  // Next state: walk the clear counter through the array, then settle in IDLE.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      ST_CLEAR: begin
        clr_cnt_d = clr_cnt_q + AW'(1);
        if (clr_cnt_q == LAST_IDX) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Choose the array write port.
  // During CLEAR it zeroes the current word; otherwise it carries a fault-free accepted store.
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = word_idx;
    wr_be   = acc_be;
    wr_data = acc_wdata;
    if (state_q == ST_CLEAR) begin
      wr_en   = 1'b1;
      wr_idx  = clr_cnt_q;
      wr_be   = 4'b1111;
      wr_data = 32'h0;
    end else if (accept && i_MemWrite && !fault) begin
      wr_en = 1'b1;
    end
  end

  // Load result and status pulses for the request accepted this cycle.
  // o_data holds its value between loads.
  always_comb begin
    data_d         = data_q;
    valid_d        = 1'b0;
    misaligned_d   = accept && acc_misaligned;
    out_of_range_d = accept && acc_out_of_range;
    if (accept && i_MemRead) begin
      valid_d = 1'b1;
      data_d  = fault ? 32'h0 : acc_rdata;
    end
  end

  // Controller and output registers.
  // Reset is asynchronous, so it restarts the clear from index 0 at any time.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q        <= RESET_STATE;
      clr_cnt_q      <= '0;
      data_q         <= 32'h0;
      valid_q        <= 1'b0;
      misaligned_q   <= 1'b0;
      out_of_range_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      clr_cnt_q      <= clr_cnt_d;
      data_q         <= data_d;
      valid_q        <= valid_d;
      misaligned_q   <= misaligned_d;
      out_of_range_q <= out_of_range_d;
    end
  end

  // Byte-lane array write.
  // It is not reset; contents are defined only once the clear sweep has run.
  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) begin
          mem_q[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
        end
      end
    end
  end

  assign o_data         = data_q;
  assign o_valid        = valid_q;
  assign o_misaligned   = misaligned_q;
  assign o_out_of_range = out_of_range_q;

endmodule

// File: tb/tb_data_mem_be.sv
// Self-checking bench for data_mem_be with a 16-word array and clear-on-reset.
// It runs a hand-written vector table, then random traffic against a byte-array reference model.
// The last section covers reset during an access and during the clear sweep.
module tb_data_mem_be;

  localparam int DEPTH = 16;
  localparam int BYTES = DEPTH * 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_write, mem_read, is_unsigned;
  logic [1:0]  size;
  logic [31:0] address, wdata;
  logic [31:0] rdata;
  logic        valid, ready, misaligned, out_of_range;

  int checks = 0;
  int errors = 0;

  logic [7:0]  ref_bytes [BYTES];
  logic [31:0] last_load;

  typedef struct {
    logic        wr;
    logic        rd;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp_data;
    logic        exp_valid;
    logic        exp_mis;
    logic        exp_oor;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  data_mem_be #(.DEPTH_WORDS(DEPTH), .CLEAR_ON_RESET(1'b1)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_MemWrite     (mem_write),
    .i_MemRead      (mem_read),
    .i_size         (size),
    .i_unsigned     (is_unsigned),
    .i_address      (address),
    .i_data         (wdata),
    .o_data         (rdata),
    .o_valid        (valid),
    .o_ready        (ready),
    .o_misaligned   (misaligned),
    .o_out_of_range (out_of_range)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    mem_write   = 1'b0;
    mem_read    = 1'b0;
    size        = 2'b10;
    is_unsigned = 1'b0;
    address     = 32'h0;
    wdata       = 32'h0;
  endtask

  // Drive one request, let the next rising edge take it, and return 1 time unit later.
  task automatic applyStimulus(input logic wr, input logic rd, input logic [1:0] sz,
                               input logic uns, input logic [31:0] addr, input logic [31:0] data);
    mem_write   = wr;
    mem_read    = rd;
    size        = sz;
    is_unsigned = uns;
    address     = addr;
    wdata       = data;
    @(posedge clk);
    #1;
  endtask

  // Reference model built on a byte array: the access width is 1, 2 or 4 bytes.
  task automatic model_access(input logic wr, input logic rd, input logic [1:0] sz,
                              input logic uns, input logic [31:0] addr, input logic [31:0] data,
                              output logic [31:0] exp_data, output logic exp_valid,
                              output logic exp_mis, output logic exp_oor);
    int          n;
    logic        mis, oor;
    logic [31:0] val;
    n   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    mis = (sz == 2'd3) || ((addr & 32'(n - 1)) != 32'h0);
    oor = addr >= 32'(BYTES);
    exp_mis   = (wr || rd) && mis;
    exp_oor   = (wr || rd) && oor;
    exp_valid = rd;
    if (rd) begin
      val = 32'h0;
      if (!mis && !oor) begin
        for (int k = 0; k < n; k++) begin
          val = val | (32'(ref_bytes[addr[5:0] + 6'(k)]) << (8 * k));
        end
        if (!uns && n < 4 && val[8*n-1]) begin
          val = val | (32'hFFFF_FFFF << (8 * n));
        end
      end
      last_load = val;
    end
    exp_data = last_load;
    if (wr && !mis && !oor) begin
      for (int k = 0; k < n; k++) begin
        ref_bytes[addr[5:0] + 6'(k)] = data[8*k +: 8];
      end
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < BYTES; i++) ref_bytes[i] = 8'h00;
    last_load = 32'h0;
  endtask

  function automatic void add_vec(input logic wr, input logic rd, input logic [1:0] sz,
                                  input logic uns, input logic [31:0] addr, input logic [31:0] data,
                                  input logic [31:0] exp_data, input logic exp_valid,
                                  input logic exp_mis, input logic exp_oor);
    vec_t v;
    v.wr = wr; v.rd = rd; v.size = sz; v.uns = uns; v.addr = addr; v.data = data;
    v.exp_data = exp_data; v.exp_valid = exp_valid; v.exp_mis = exp_mis; v.exp_oor = exp_oor;
    vecs.push_back(v);
  endfunction

  task automatic check_all(input string tag, input logic [31:0] exp_data, input logic exp_valid,
                           input logic exp_mis, input logic exp_oor);
    checkOutput({tag, " data"}, rdata, exp_data);
    checkOutput({tag, " valid"}, 32'(valid), 32'(exp_valid));
    checkOutput({tag, " misaligned"}, 32'(misaligned), 32'(exp_mis));
    checkOutput({tag, " out_of_range"}, 32'(out_of_range), 32'(exp_oor));
  endtask

  // Count rising edges until o_ready is high; a count of 200 means it never came.
  task automatic wait_ready(output int n);
    n = 0;
    while (!ready && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          n;
    logic [31:0] ed;
    logic        ev, em, eo;
    logic        wr, rd, uns;
    logic [1:0]  sz;
    logic [31:0] addr, data;

    rst_n = 1'b0;
    drive_idle();
    #12;
    checkOutput("reset ready", 32'(ready), 32'h0);
    check_all("reset", 32'h0, 1'b0, 1'b0, 1'b0);

    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_ready(n);
    checkOutput("clear cycles", 32'(n), 32'd16);
    model_clear();

    for (int w = 0; w < DEPTH; w++) begin
      applyStimulus(1'b0, 1'b1, 2'd2, 1'b0, 32'(w * 4), 32'h0);
      checkOutput($sformatf("cleared word %0d", w), rdata, 32'h0);
      checkOutput($sformatf("cleared word %0d valid", w), 32'(valid), 32'h1);
    end

    add_vec(1'b1, 1'b0, 2'd2, 1'b0, 32'h08, 32'h8000_00FF, 32'h0000_0000, 1'b0, 1'b0, 1'b0);
    add_vec(1'b0, 1'b1, 2'd0, 1'b0, 32'h08, 32'h0,         32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    add_vec(1'b0, 1'b1, 2'd0, 1'b1, 32'h08, 32'h0,         32'h0000_00FF, 1'b1, 1'b0, 1'b0);
    add_vec(1'b0, 1'b1, 2'd1, 1'b0, 32'h0A, 32'h0,         32'hFFFF_8000, 1'b1, 1'b0, 1'b0);
    add_vec(1'b0, 1'b1, 2'd2, 1'b0, 32'h08, 32'h0,         32'h8000_00FF, 1'b1, 1'b0, 1'b0);
    add_vec(1'b1, 1'b0, 2'd2, 1'b0, 32'h04, 32'h1122_3344, 32'h8000_00FF, 1'b0, 1'b0, 1'b0);
    add_vec(1'b1, 1'b0, 2'd0, 1'b0, 32'h05, 32'h0000_00AA, 32'h8000_00FF, 1'b0, 1'b0, 1'b0);
    add_vec(1'b0, 1'b1, 2'd2, 1'b0, 32'h04, 32'h0,         32'h1122_AA44, 1'b1, 1'b0, 1'b0);
    add_vec(1'b1, 1'b0, 2'd1, 1'b0, 32'h06, 32'h0000_BEEF, 32'h1122_AA44, 1'b0, 1'b0, 1'b0);
    add_vec(1'b0, 1'b1, 2'd2, 1'b0, 32'h04, 32'h0,         32'hBEEF_AA44, 1'b1, 1'b0, 1'b0);
    add_vec(1'b0, 1'b1, 2'd2, 1'b0, 32'h02, 32'h0,         32'h0000_0000, 1'b1, 1'b1, 1'b0);
    add_vec(1'b1, 1'b0, 2'd1, 1'b0, 32'h03, 32'h0000_1234, 32'h0000_0000, 1'b0, 1'b1, 1'b0);
    add_vec(1'b0, 1'b1, 2'd3, 1'b0, 32'h04, 32'h0,         32'h0000_0000, 1'b1, 1'b1, 1'b0);
    add_vec(1'b1, 1'b0, 2'd3, 1'b0, 32'h08, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1, 1'b0);
    add_vec(1'b0, 1'b1, 2'd2, 1'b0, 32'h04, 32'h0,         32'hBEEF_AA44, 1'b1, 1'b0, 1'b0);
    add_vec(1'b0, 1'b1, 2'd2, 1'b0, 32'h08, 32'h0,         32'h8000_00FF, 1'b1, 1'b0, 1'b0);
    add_vec(1'b1, 1'b0, 2'd2, 1'b0, 32'h40, 32'hDEAD_BEEF, 32'h8000_00FF, 1'b0, 1'b0, 1'b1);
    add_vec(1'b0, 1'b1, 2'd2, 1'b0, 32'h40, 32'h0,         32'h0000_0000, 1'b1, 1'b0, 1'b1);
    add_vec(1'b0, 1'b1, 2'd2, 1'b0, 32'h00, 32'h0,         32'h0000_0000, 1'b1, 1'b0, 1'b0);
    add_vec(1'b1, 1'b1, 2'd2, 1'b0, 32'h00, 32'hCAFE_F00D, 32'h0000_0000, 1'b1, 1'b0, 1'b0);
    add_vec(1'b0, 1'b1, 2'd2, 1'b0, 32'h00, 32'h0,         32'hCAFE_F00D, 1'b1, 1'b0, 1'b0);
    add_vec(1'b0, 1'b1, 2'd1, 1'b0, 32'h43, 32'h0,         32'h0000_0000, 1'b1, 1'b1, 1'b1);
    add_vec(1'b0, 1'b1, 2'd1, 1'b1, 32'h06, 32'h0,         32'h0000_BEEF, 1'b1, 1'b0, 1'b0);
    add_vec(1'b0, 1'b1, 2'd1, 1'b0, 32'h06, 32'h0,         32'hFFFF_BEEF, 1'b1, 1'b0, 1'b0);
    add_vec(1'b0, 1'b1, 2'd0, 1'b0, 32'h05, 32'h0,         32'hFFFF_FFAA, 1'b1, 1'b0, 1'b0);
    add_vec(1'b0, 1'b1, 2'd0, 1'b1, 32'h07, 32'h0,         32'h0000_00BE, 1'b1, 1'b0, 1'b0);
    add_vec(1'b0, 1'b0, 2'd2, 1'b0, 32'h04, 32'h0,         32'h0000_00BE, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      model_access(vecs[i].wr, vecs[i].rd, vecs[i].size, vecs[i].uns, vecs[i].addr,
                   vecs[i].data, ed, ev, em, eo);
      applyStimulus(vecs[i].wr, vecs[i].rd, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].data);
      check_all($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_valid,
                vecs[i].exp_mis, vecs[i].exp_oor);
    end

    for (int i = 0; i < 300; i++) begin
      wr   = 1'($urandom_range(0, 1));
      rd   = 1'($urandom_range(0, 1));
      sz   = 2'($urandom_range(0, 3));
      uns  = 1'($urandom_range(0, 1));
      addr = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, BYTES + 15));
      data = $urandom;
      model_access(wr, rd, sz, uns, addr, data, ed, ev, em, eo);
      applyStimulus(wr, rd, sz, uns, addr, data);
      check_all($sformatf("rand%0d", i), ed, ev, em, eo);
    end

    applyStimulus(1'b1, 1'b0, 2'd2, 1'b0, 32'h0, 32'h5A5A_1234);
    applyStimulus(1'b0, 1'b1, 2'd2, 1'b0, 32'h0, 32'h0);
    checkOutput("pre-reset load data", rdata, 32'h5A5A_1234);
    checkOutput("pre-reset load valid", 32'(valid), 32'h1);
    drive_idle();
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async reset ready", 32'(ready), 32'h0);
    check_all("async reset", 32'h0, 1'b0, 1'b0, 1'b0);

    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
    end
    checkOutput("mid-clear ready", 32'(ready), 32'h0);
    rst_n = 1'b0;
    #1;
    checkOutput("mid-clear reset ready", 32'(ready), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    n = 0;
    while (!ready && n < 200) begin
      if (n < 10) begin
        if (n % 2 == 0) begin
          mem_write = 1'b1; mem_read = 1'b1; size = 2'd2; is_unsigned = 1'b0;
          address = 32'h0; wdata = 32'h1234_5678;
        end else begin
          mem_write = 1'b1; mem_read = 1'b1; size = 2'd3; is_unsigned = 1'b0;
          address = 32'h101; wdata = 32'h8765_4321;
        end
      end else begin
        drive_idle();
      end
      @(posedge clk);
      #1;
      n++;
      if (n <= 10) begin
        check_all($sformatf("ignored req %0d", n), 32'h0, 1'b0, 1'b0, 1'b0);
      end
    end
    drive_idle();
    checkOutput("restart clear cycles", 32'(n), 32'd16);
    model_clear();

    applyStimulus(1'b0, 1'b1, 2'd2, 1'b0, 32'h0, 32'h0);
    check_all("post-clear word 0", 32'h0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 2'd2, 1'b0, 32'h4, 32'h0);
    check_all("post-clear word 1", 32'h0, 1'b1, 1'b0, 1'b0);
    drive_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
